// File: rtl/wave_gen_pkg.sv
// Shared types and reset constants for the multi-mode waveform generator.
package wave_gen_pkg;

    typedef enum logic [1:0] {
        SAW_UP   = 2'd0,
        SAW_DOWN = 2'd1,
        TRIANGLE = 2'd2,
        SQUARE   = 2'd3
    } wave_mode_t;

    localparam wave_mode_t MODE_RESET = SAW_UP;

endpackage

// File: rtl/wave_phase_acc.sv
// Phase accumulator: adds step on enabled cycles, flags the carry-out
// that marks a period wrap, and can be cleared to zero.
module wave_phase_acc #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic [ACC_W-1:0] step,
    output logic [ACC_W-1:0] phase,
    output logic             carry
);

    logic [ACC_W:0] sum;

    assign sum   = {1'b0, phase} + {1'b0, step};
    assign carry = en & ~clear & sum[ACC_W];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            phase <= '0;
        end else if (en) begin
            phase <= sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/multi_mode_wave_generator.sv
// Programmable waveform source: phase accumulator, four shapes, and a
// valid/ready configuration port whose settings take effect at a period wrap.
module multi_mode_wave_generator
    import wave_gen_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [ACC_W-1:0] cfg_step,
    input  logic [WIDTH-1:0] cfg_duty,
    output logic [WIDTH-1:0] wave_out,
    output logic             wave_valid,
    output logic             wrap
);

    typedef struct packed {
        wave_mode_t       mode;
        logic [ACC_W-1:0] step;
        logic [WIDTH-1:0] duty;
    } cfg_t;

    localparam logic [ACC_W-1:0] STEP_RESET = ACC_W'(1) << (ACC_W - WIDTH);
    localparam logic [WIDTH-1:0] DUTY_RESET = WIDTH'(1) << (WIDTH - 1);
    localparam cfg_t CFG_RESET = '{mode: MODE_RESET, step: STEP_RESET, duty: DUTY_RESET};

    cfg_t             shadow;
    cfg_t             active;
    logic             pending;
    logic             accept;
    logic             force_apply;
    logic             apply;
    logic             phase_wrapped;
    logic [ACC_W-1:0] phase;
    logic             carry;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] tri_t;
    logic [WIDTH-1:0] shape;

    assign cfg_ready   = ~pending;
    assign accept      = cfg_valid & ~pending;
    // A stalled or zero-step accumulator never carries, so apply at once and restart the period.
    assign force_apply = pending & (~en | (active.step == '0));
    assign apply       = pending & (carry | force_apply);

    wave_phase_acc #(
        .ACC_W(ACC_W)
    ) u_phase_acc (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clear (force_apply),
        .step  (active.step),
        .phase (phase),
        .carry (carry)
    );

    assign p     = phase[ACC_W-1 -: WIDTH];
    assign tri_t = {p[WIDTH-2:0], 1'b0};

    always_comb begin
        // NOTE: assign a default before the case so no path leaves shape unassigned (no latch).
        shape = '0;
        unique case (active.mode)
            SAW_UP:   shape = p;
            SAW_DOWN: shape = ~p;
            TRIANGLE: shape = p[WIDTH-1] ? ~tri_t : tri_t;
            SQUARE:   shape = (p < active.duty) ? '1 : '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow        <= CFG_RESET;
            active        <= CFG_RESET;
            pending       <= 1'b0;
            phase_wrapped <= 1'b0;
            wave_out      <= '0;
            wave_valid    <= 1'b0;
            wrap          <= 1'b0;
        end else begin
            if (accept) begin
                shadow  <= '{mode: wave_mode_t'(cfg_mode), step: cfg_step, duty: cfg_duty};
                pending <= 1'b1;
            end
            if (apply) begin
                active  <= shadow;
                pending <= 1'b0;
            end
            // Remembers that the held phase came from a carry until a valid sample reports it.
            if (force_apply) begin
                phase_wrapped <= 1'b0;
            end else if (en) begin
                phase_wrapped <= carry;
            end
            wave_out   <= shape;
            wave_valid <= en;
            wrap       <= phase_wrapped & en;
        end
    end

endmodule

// File: tb/tb_multi_mode_wave_generator.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an arithmetic model.
module tb_multi_mode_wave_generator;

    localparam int WIDTH = 8;
    localparam int ACC_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             en = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [1:0]       cfg_mode = 2'd0;
    logic [ACC_W-1:0] cfg_step = '0;
    logic [WIDTH-1:0] cfg_duty = '0;
    logic [WIDTH-1:0] wave_out;
    logic             wave_valid;
    logic             wrap;

    multi_mode_wave_generator #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_mode   (cfg_mode),
        .cfg_step   (cfg_step),
        .cfg_duty   (cfg_duty),
        .wave_out   (wave_out),
        .wave_valid (wave_valid),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int m_phase, m_step, m_duty, m_mode;
    int s_phase_unused;
    int s_step, s_duty, s_mode;
    bit m_pend, m_wrapped, was_pend, model_live = 1'b0;
    int m_sum;
    int e_out, e_valid, e_wrap, e_ready;

    function automatic int shape_of(input int ph, input int mode, input int duty);
        int pp;
        pp = ph / 256;
        case (mode)
            0: return pp;
            1: return 255 - pp;
            2: return (pp < 128) ? 2 * pp : 255 - 2 * (pp - 128);
            default: return (pp < duty) ? 255 : 0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_step = 256; m_duty = 128; m_mode = 0;
            m_pend = 0; m_wrapped = 0;
            e_out = 0; e_valid = 0; e_wrap = 0; e_ready = 1;
            model_live = 1'b1;
        end else if (model_live) begin
            e_out   = shape_of(m_phase, m_mode, m_duty);
            e_valid = en;
            e_wrap  = en && m_wrapped;
            was_pend = m_pend;
            if (m_pend && (!en || m_step == 0)) begin
                m_mode = s_mode; m_step = s_step; m_duty = s_duty;
                m_phase = 0; m_wrapped = 0; m_pend = 0;
            end else if (en) begin
                m_sum     = m_phase + m_step;
                m_wrapped = (m_sum >= 65536);
                m_phase   = m_sum % 65536;
                if (m_wrapped && m_pend) begin
                    m_mode = s_mode; m_step = s_step; m_duty = s_duty;
                    m_pend = 0;
                end
            end
            if (!was_pend && cfg_valid) begin
                s_mode = cfg_mode; s_step = cfg_step; s_duty = cfg_duty;
                m_pend = 1;
            end
            e_ready = !m_pend;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("model_wave_out", wave_out, e_out);
            check("model_wave_valid", wave_valid, e_valid);
            check("model_wrap", wrap, e_wrap);
            check("model_cfg_ready", cfg_ready, e_ready);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic offer(input int mode, input int step, input int duty);
        int guard = 0;
        cfg_valid = 1'b1;
        cfg_mode  = mode[1:0];
        cfg_step  = step[ACC_W-1:0];
        cfg_duty  = duty[WIDTH-1:0];
        while (cfg_ready !== 1'b1 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("offer_accepted_in_time", guard < 3000, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_wrap(input string name);
        int guard = 0;
        while (wrap !== 1'b1 && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        check(name, guard < 600, 1);
    endtask

    task automatic wait_ready(input string name);
        int guard = 0;
        while (cfg_ready !== 1'b1 && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        check(name, guard < 600, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int cnt;
        int hi;

        tick(3);
        reset = 1'b0;
        check("reset_wave_out", wave_out, 0);
        check("reset_wave_valid", wave_valid, 0);
        check("reset_wrap", wrap, 0);
        check("reset_cfg_ready", cfg_ready, 1);

        // Default saw-up ramp 0..255 then wrap to 0.
        en = 1'b1;
        for (int i = 0; i <= 256; i++) begin
            tick();
            check("t1_ramp", wave_out, i % 256);
            check("t1_wrap", wrap, (i == 256) ? 1 : 0);
            check("t1_valid", wave_valid, 1);
        end

        // Mid-period switch to SAW_DOWN, step 0x200.
        tick(20);
        offer(1, 'h0200, 128);
        check("t2_ready_low", cfg_ready, 0);
        wait_wrap("t2_wrap_seen");
        check("t2_first_sample", wave_out, 255);
        check("t2_ready_back", cfg_ready, 1);
        tick();
        check("t2_second_sample", wave_out, 253);
        cnt = 1;
        tick();
        while (wrap !== 1'b1 && cnt < 300) begin
            tick();
            cnt++;
        end
        check("t2_period", cnt + 1, 128);

        // Triangle, step 0x100.
        offer(2, 'h0100, 128);
        wait_wrap("t3_wrap_seen");
        check("t3_start", wave_out, 0);
        tick(127);
        check("t3_top_even", wave_out, 254);
        tick();
        check("t3_peak", wave_out, 255);
        tick();
        check("t3_descend", wave_out, 253);

        // Square with duty 64, then duty 0.
        offer(3, 'h0100, 64);
        wait_wrap("t4_wrap_seen");
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            if (wave_out == 8'hFF) hi++;
            tick();
        end
        check("t4_high_count", hi, 64);
        offer(3, 'h0100, 0);
        wait_wrap("t4_duty0_wrap_seen");
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            if (wave_out != 8'h00) hi++;
            tick();
        end
        check("t4_duty0_nonzero", hi, 0);

        // Pending cfg with en=0 applies next edge and clears phase.
        offer(3, 'h0100, 64);
        en = 1'b0;
        tick();
        check("t5_valid_low", wave_valid, 0);
        check("t5_ready_back", cfg_ready, 1);
        en = 1'b1;
        tick();
        check("t5_phase_cleared", wave_out, 255);
        check("t5_no_wrap", wrap, 0);

        // Zero active step: a pending cfg applies immediately.
        offer(0, 0, 128);
        wait_ready("t5_step0_applied");
        tick(3);
        offer(1, 'h0100, 128);
        check("t5_step0_ready_low", cfg_ready, 0);
        tick();
        check("t5_step0_ready_back", cfg_ready, 1);
        tick();
        check("t5_step0_new_mode", wave_out, 255);

        // Reset mid-period with a configuration pending.
        offer(2, 'h0300, 10);
        tick(5);
        reset = 1'b1;
        tick();
        check("t6_wave_out", wave_out, 0);
        check("t6_wrap", wrap, 0);
        check("t6_cfg_ready", cfg_ready, 1);
        check("t6_valid", wave_valid, 0);
        reset = 1'b0;
        tick();
        check("t6_saw_up_0", wave_out, 0);
        tick();
        check("t6_saw_up_1", wave_out, 1);

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 2500; cyc++) begin
            tick();
            reset = ($urandom_range(0, 399) == 0);
            en    = ($urandom_range(0, 7) != 0);
            if (!(cfg_valid && !cfg_ready)) begin
                cfg_valid = ($urandom_range(0, 19) == 0);
                cfg_mode  = 2'($urandom_range(0, 3));
                cfg_duty  = 8'($urandom_range(0, 255));
                case ($urandom_range(0, 3))
                    0: cfg_step = '0;
                    1: cfg_step = 16'($urandom_range(1, 'h3FF));
                    2: cfg_step = 16'($urandom_range('h400, 'hFFFF));
                    default: cfg_step = 16'(16'h0100 << $urandom_range(0, 4));
                endcase
            end
        end

        reset = 1'b0;
        cfg_valid = 1'b0;
        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
